// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU fetch/data memory arbiter.
// No logic: state encoding, abort read value, default limits, address helper.
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arbState_t;

  // Read value returned to the CPU when a transaction is abandoned on timeout.
  localparam logic [31:0] ABORT_RDATA = 32'hDEADBEEF;

  localparam int DEFAULT_MAX_D_STREAK = 4;
  localparam int DEFAULT_TIMEOUT      = 16;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Single-outstanding memory port: request held with stable fields until a one-cycle m_ready.
// The arbiter drives the master side; the memory model or controller sits on the slave side.
interface cpu_mem_arbiter_if;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/cpu_mem_arbiter_timer.sv
// Per-grant watchdog: restarts from zero on load, counts enabled cycles, no backpressure.
// expired is combinational and rises in the TIMEOUT-th enabled cycle after a load.
module cpu_mem_arb_timer
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; grant one cycle after request, ack one cycle after m_ready or timeout.
// CPU sees stall until its ack; data wins ties unless MAX_D_STREAK data grants have passed a waiting fetch.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic [31:0]              i_rdata,
  output logic                     i_ack,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic [31:0]              d_rdata,
  output logic                     d_ack,
  cpu_mem_arbiter_if.master        memBus,
  output logic                     stall,
  output logic                     err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arbState_t     state;
  logic [SW-1:0] dStreak;
  logic          iEligible;
  logic          dEligible;
  logic          grantD;
  logic          grantI;
  logic          timedOut;

  // A requester still seeing its own ack is finishing, not asking again.
  assign iEligible = i_req && !i_ack;
  assign dEligible = d_req && !d_ack;

  assign grantD = (state == IDLE) && dEligible &&
                  ((dStreak < SW'(MAX_D_STREAK)) || !iEligible);
  assign grantI = (state == IDLE) && iEligible && !grantD;

  assign stall = (i_req && !i_ack) || (d_req && !d_ack);

  cpu_mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (state == IDLE),
    .enable  (state != IDLE),
    .expired (timedOut)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      dStreak        <= '0;
      memBus.m_req   <= 1'b0;
      memBus.m_we    <= 1'b0;
      memBus.m_addr  <= '0;
      memBus.m_wdata <= '0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      err            <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state          <= GRANT_D;
            memBus.m_req   <= 1'b1;
            memBus.m_we    <= d_we;
            memBus.m_addr  <= wordAlign(d_addr);
            memBus.m_wdata <= d_wdata;
            if (!i_req) begin
              dStreak <= '0;
            end else if (dStreak < SW'(MAX_D_STREAK)) begin
              dStreak <= dStreak + 1'b1;
            end
          end else if (grantI) begin
            state         <= GRANT_I;
            memBus.m_req  <= 1'b1;
            memBus.m_we   <= 1'b0;
            memBus.m_addr <= wordAlign(i_addr);
            dStreak       <= '0;
          end
        end
        GRANT_I: begin
          if (memBus.m_ready || timedOut) begin
            state        <= IDLE;
            memBus.m_req <= 1'b0;
            i_ack        <= 1'b1;
            if (memBus.m_ready) begin
              i_rdata <= memBus.m_rdata;
            end else begin
              i_rdata <= ABORT_RDATA;
              err     <= 1'b1;
            end
          end
        end
        GRANT_D: begin
          if (memBus.m_ready || timedOut) begin
            state        <= IDLE;
            memBus.m_req <= 1'b0;
            d_ack        <= 1'b1;
            // Store completions keep the last load value visible to the CPU.
            if (!memBus.m_ready) begin
              d_rdata <= ABORT_RDATA;
              err     <= 1'b1;
            end else if (!memBus.m_we) begin
              d_rdata <= memBus.m_rdata;
            end
          end
        end
        default: begin
          state        <= IDLE;
          memBus.m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_cpu_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall;
  logic        err;

  int checks;
  int failures;

  cpu_mem_arbiter_if memBus ();

  cpu_mem_arbiter #(
    .MAX_D_STREAK (4),
    .TIMEOUT      (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .memBus  (memBus),
    .stall   (stall),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One row per clock cycle: inputs held for the cycle, outputs expected during it.
  typedef struct {
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] mRdata;
    logic        mReady;
    logic        expMReq;
    logic        expMWe;
    logic [31:0] expMAddr;
    logic [31:0] expMWdata;
    logic        expIAck;
    logic        expDAck;
    logic [31:0] expIRdata;
    logic [31:0] expDRdata;
    logic        expStall;
    logic        expErr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // fetch 0x10, store to 0x43, idle m_ready, then a D/I collision
    vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        32'h20080005, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h20080005, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h20080005, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h43, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h20080005, 32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h43, 32'hA5A5A5A5, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h20080005, 32'h0,        1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h43, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h20080005, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        32'hFFFF0000, 1'b1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h20080005, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h20080005, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h40, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h20080005, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h20080005, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h40, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        1'b0, 1'b1, 32'h20080005, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0BADF00D, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b0, 32'h20080005, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 32'h0,        1'b1, 1'b0, 32'h0BADF00D, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h80, 32'h0,        1'b0, 1'b0, 32'h0BADF00D, 32'hCAFEF00D, 1'b0, 1'b0};

    reset          = 1'b1;
    i_req          = 1'b0;
    i_addr         = '0;
    d_req          = 1'b0;
    d_we           = 1'b0;
    d_addr         = '0;
    d_wdata        = '0;
    memBus.m_rdata = '0;
    memBus.m_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      i_req          = vecs[k].iReq;
      i_addr         = vecs[k].iAddr;
      d_req          = vecs[k].dReq;
      d_we           = vecs[k].dWe;
      d_addr         = vecs[k].dAddr;
      d_wdata        = vecs[k].dWdata;
      memBus.m_rdata = vecs[k].mRdata;
      memBus.m_ready = vecs[k].mReady;
      #1;
      check($sformatf("r%0d_m_req", k),   memBus.m_req,   vecs[k].expMReq);
      check($sformatf("r%0d_m_we", k),    memBus.m_we,    vecs[k].expMWe);
      check($sformatf("r%0d_m_addr", k),  memBus.m_addr,  vecs[k].expMAddr);
      check($sformatf("r%0d_m_wdata", k), memBus.m_wdata, vecs[k].expMWdata);
      check($sformatf("r%0d_i_ack", k),   i_ack,          vecs[k].expIAck);
      check($sformatf("r%0d_d_ack", k),   d_ack,          vecs[k].expDAck);
      check($sformatf("r%0d_i_rdata", k), i_rdata,        vecs[k].expIRdata);
      check($sformatf("r%0d_d_rdata", k), d_rdata,        vecs[k].expDRdata);
      check($sformatf("r%0d_stall", k),   stall,          vecs[k].expStall);
      check($sformatf("r%0d_err", k),     err,            vecs[k].expErr);
    end

    // Streak: fetch is only presented in arbitration cycles, so four data grants
    // in a row all count against it; the fifth tie must go to the fetch.
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0;
      d_addr = 32'h100 + 32'(4 * r); memBus.m_ready = 1'b0;
      #1 check($sformatf("starve%0d_idle", r), memBus.m_req, 1'b0);
      @(negedge clock);
      i_req = 1'b0; memBus.m_ready = 1'b1; memBus.m_rdata = 32'(r);
      #1 check($sformatf("starve%0d_d_addr", r), memBus.m_addr, 32'h100 + 32'(4 * r));
      @(negedge clock);
      memBus.m_ready = 1'b0;
      #1 check($sformatf("starve%0d_d_ack", r), d_ack, 1'b1);
    end
    @(negedge clock);
    i_req = 1'b1; d_req = 1'b1; d_addr = 32'h110;
    #1 check("starve_tie_stall", stall, 1'b1);
    @(negedge clock);
    memBus.m_ready = 1'b1; memBus.m_rdata = 32'h55;
    #1 check("starve_i_grant_addr", memBus.m_addr, 32'h200);
    check("starve_i_grant_we", memBus.m_we, 1'b0);
    @(negedge clock);
    memBus.m_ready = 1'b0;
    #1 check("starve_i_ack", i_ack, 1'b1);
    check("starve_i_rdata", i_rdata, 32'h55);
    @(negedge clock);
    i_req = 1'b0; memBus.m_ready = 1'b1; memBus.m_rdata = 32'h66;
    #1 check("restart_d_addr", memBus.m_addr, 32'h110);
    @(negedge clock);
    memBus.m_ready = 1'b0;
    #1 check("restart_d_rdata", d_rdata, 32'h66);
    @(negedge clock);
    i_req = 1'b1; d_addr = 32'h114;
    #1 check("restart_tie_idle", memBus.m_req, 1'b0);
    @(negedge clock);
    i_req = 1'b0; memBus.m_ready = 1'b1; memBus.m_rdata = 32'h77;
    #1 check("restart_tie_d_wins", memBus.m_addr, 32'h114);
    @(negedge clock);
    memBus.m_ready = 1'b0;
    #1 check("restart_tie_d_ack", d_ack, 1'b1);
    @(negedge clock);
    d_req = 1'b0;

    // Timeout: load to 0x300 never answered; abort ack 16 cycles after m_req rises.
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    #1 check("timeout_err_before", err, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      @(negedge clock);
      #1 check($sformatf("timeout_wait%0d_d_ack", t), d_ack, 1'b0);
      check($sformatf("timeout_wait%0d_m_req", t), memBus.m_req, 1'b1);
    end
    @(negedge clock);
    #1 check("timeout_d_ack", d_ack, 1'b1);
    check("timeout_d_rdata", d_rdata, 32'hDEADBEEF);
    check("timeout_err", err, 1'b1);
    check("timeout_m_req", memBus.m_req, 1'b0);
    @(negedge clock);
    d_req = 1'b0;
    repeat (3) @(negedge clock);
    #1 check("timeout_err_sticky", err, 1'b1);

    // Reset while a store is granted: the transaction is dropped without an ack.
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h77;
    @(negedge clock);
    #1 check("rst_grant_m_req", memBus.m_req, 1'b1);
    check("rst_grant_m_addr", memBus.m_addr, 32'h500);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1 check("rst_m_req", memBus.m_req, 1'b0);
    check("rst_m_we", memBus.m_we, 1'b0);
    check("rst_m_addr", memBus.m_addr, 32'h0);
    check("rst_m_wdata", memBus.m_wdata, 32'h0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_err", err, 1'b0);
    @(negedge clock);
    #1 check("rst_after_d_ack", d_ack, 1'b0);
    check("rst_after_m_req", memBus.m_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
